soc_noc_wb_responder: RTL
=========================

Name: soc_noc_wb_responder

Overview:
- NoC-to-Wishbone target bridge for memory and peripheral tiles; the responder end of single-word load/store request packets issued by compute-tile adapters.
- Receives one request packet at a time on a NoC input channel and performs exactly one Wishbone classic master cycle.
- Returns a response packet to the requesting tile on a NoC output channel.
- Strictly one outstanding transaction; no internal buffering beyond the packet registers.

Parameters:
- FLIT_WIDTH, 32, flit width; fixed at 32 in this revision.
- TILEID, 0, source id inserted in response headers; 5 bits.
- CLASS_RES, 3'h1, packet class written into response headers.
- WB_TIMEOUT, 255, maximum wait for Wishbone termination in cycles, 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- noc_in_flit  in  32  request flit
- noc_in_last  in  1  last flit of the request packet
- noc_in_valid  in  1  request flit valid
- noc_in_ready  out  1  request flit accepted
- noc_out_flit  out  32  response flit
- noc_out_last  out  1  last flit of the response packet
- noc_out_valid  out  1  response flit valid
- noc_out_ready  in  1  downstream accepts the response flit
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_sel_o  out  4  Wishbone byte select
- wbm_we_o  out  1  Wishbone write enable
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_err_i  in  1  Wishbone error
- wbm_rty_i  in  1  Wishbone retry
- drop_o  out  1  one-cycle pulse when a malformed packet is discarded

Behaviour:
- Request header fields: [31:27] dest, [26:24] class, [23:19] src, [18] we, [17:14] sel; remaining bits ignored.
- Write request: header, addr, data; 3 flits, last set on the data flit.
- Read request: header, addr; 2 flits, last set on the addr flit.
- Response header fields: [31:27] = latched src, [26:24] = CLASS_RES, [23:19] = TILEID, [18] = latched we, [0] = error flag; all other bits 0.
- Read response: header + data flit (2 flits). Write response: header only.
- Reset (rst=0, asynchronous): state RX_HDR; all outputs 0; timeout counter 0.
- Flit transfers occur when valid && ready.
- FSM transitions:
  - RX_HDR: noc_in_ready=1. On header accept, latch src, we, sel. If last=1, go to DRAIN_DONE; otherwise go to RX_ADDR.
  - RX_ADDR: noc_in_ready=1. Latch address.
    - read with last=1: go to WB.
    - read with last=0: go to DRAIN.
    - write with last=1: go to DRAIN_DONE (packet too short).
    - write with last=0: go to RX_DATA.
  - RX_DATA: noc_in_ready=1. Latch data. If last=1, go to WB; otherwise go to DRAIN.
  - DRAIN: noc_in_ready=1. Accept and discard flits until the last flit is accepted, then go to DRAIN_DONE.
  - DRAIN_DONE: drop_o=1 for exactly one cycle, then go to RX_HDR. No Wishbone cycle is issued and no response is sent for the malformed packet.
  - WB: cyc=stb=1 from the first WB cycle; adr/dat/sel/we are stable and come from registers. noc_in_ready=0 in WB and in all TX states.
    - ack=1: capture wbm_dat_i (read) and clear the error flag.
    - err=1 or rty=1: set the error flag. rty is not retried.
    - Counter reaches WB_TIMEOUT with no termination: set the error flag.
    - On any termination, deassert cyc/stb in the next cycle and go to TX_HDR.
    - Simultaneous ack and err/rty: err wins.
    - Termination latency: minimum one WB cycle (ack in the same cycle as stb).
  - TX_HDR: noc_out_valid=1 and header presented. last=1 for writes.
    - Hold the flit and valid until ready.
    - Write: on handshake, go to RX_HDR.
    - Read: on handshake, go to TX_DATA.
  - TX_DATA: presents read data with last=1; on handshake, go to RX_HDR. Data is 0 if the error flag is set.
- Latency:
  - Last request flit accepted to cyc rising: 1 cycle.
  - Wishbone termination to noc_out_valid: 1 cycle.
  - Back-to-back packets: the next header is accepted the cycle after the response's last handshake.
- Timeout counter: 8-bit, cleared on WB entry, saturating.
- Reset asserted mid-transaction drops cyc/stb/valid immediately; no partial response is completed.

Test Plan:
- Write: hdr src=3 we=1 sel=F, addr 0x100, data 0xDEADBEEF; ack after 2 cycles -> one cycle with cyc/stb/we=1, adr=0x100, dat=0xDEADBEEF; single response flit, dest=3, [18]=1, bit0=0, last=1.
- Read with backpressure: hdr src=7 we=0, addr 0x40; ack with dat_i=0x12345678; noc_out_ready=0 for 5 cycles -> header held stable; then 2 flits, data flit 0x12345678 with last=1.
- Error/timeout: read answered by wbm_err_i -> response error bit0=1 and data 0. Repeat with no ack -> cyc drops after 255 cycles, error response sent.
- Malformed packets:
  - Write header with last on addr -> no cyc, no response, drop_o pulses once.
  - 4-flit read -> drained, drop_o pulses once.
  - A following valid read is then served normally.
- Ack and rty asserted together -> error flag=1.
- Reset asserted while in WB -> cyc/stb/noc_out_valid=0 immediately; FSM resumes at RX_HDR after reset release.

Source files
------------

// File: rtl/soc_noc_wb_responder.sv
// soc_noc_wb_responder: NoC request packets in, one Wishbone classic
// master cycle per packet, response packet back to the requesting tile.
module soc_noc_wb_responder #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter logic [4:0]  TILEID     = 5'd0,
    parameter logic [2:0]  CLASS_RES  = 3'h1,
    parameter int unsigned WB_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] noc_in_flit,
    input  logic                  noc_in_last,
    input  logic                  noc_in_valid,
    output logic                  noc_in_ready,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic                  noc_out_last,
    output logic                  noc_out_valid,
    input  logic                  noc_out_ready,
    output logic [31:0]           wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    output logic [3:0]            wbm_sel_o,
    output logic                  wbm_we_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  wbm_rty_i,
    output logic                  drop_o
);

    typedef enum logic [2:0] {
        RX_HDR,
        RX_ADDR,
        RX_DATA,
        DRAIN,
        DRAIN_DONE,
        WB,
        TX_HDR,
        TX_DATA
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(WB_TIMEOUT);

    state_t      state;
    logic [4:0]  src_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [7:0]  cnt_q;

    logic        in_hs;
    logic        out_hs;
    logic        wb_bad;
    logic        wb_done;
    logic        err_nxt;
    logic [7:0]  cnt_inc;
    logic [31:0] rsp_hdr;

    assign in_hs   = noc_in_valid & noc_in_ready;
    assign out_hs  = noc_out_valid & noc_out_ready;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // err and rty both end the cycle as a failure; err beats a coincident ack
    assign wb_bad  = wbm_err_i | wbm_rty_i;
    assign wb_done = wbm_ack_i | wb_bad | (cnt_inc >= TIMEOUT);
    assign err_nxt = wb_bad | ~wbm_ack_i;
    assign rsp_hdr = {src_q, CLASS_RES, TILEID, wbm_we_o, 17'd0, err_nxt};

    // Packet FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RX_HDR;
            src_q         <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            noc_in_ready  <= 1'b0;
            noc_out_flit  <= '0;
            noc_out_last  <= 1'b0;
            noc_out_valid <= 1'b0;
            wbm_adr_o     <= '0;
            wbm_dat_o     <= '0;
            wbm_sel_o     <= '0;
            wbm_we_o      <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            drop_o        <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            unique case (state)
                RX_HDR: begin
                    noc_in_ready <= 1'b1;
                    if (in_hs) begin
                        src_q     <= noc_in_flit[23:19];
                        wbm_we_o  <= noc_in_flit[18];
                        wbm_sel_o <= noc_in_flit[17:14];
                        if (noc_in_last) begin
                            state        <= DRAIN_DONE;
                            noc_in_ready <= 1'b0;
                            drop_o       <= 1'b1;
                        end else begin
                            state <= RX_ADDR;
                        end
                    end
                end
                RX_ADDR: begin
                    if (in_hs) begin
                        wbm_adr_o <= noc_in_flit;
                        if (noc_in_last) begin
                            noc_in_ready <= 1'b0;
                            if (wbm_we_o) begin
                                state  <= DRAIN_DONE;
                                drop_o <= 1'b1;
                            end else begin
                                state     <= WB;
                                cnt_q     <= '0;
                                wbm_cyc_o <= 1'b1;
                                wbm_stb_o <= 1'b1;
                            end
                        end else begin
                            state <= wbm_we_o ? RX_DATA : DRAIN;
                        end
                    end
                end
                RX_DATA: begin
                    if (in_hs) begin
                        wbm_dat_o <= noc_in_flit;
                        if (noc_in_last) begin
                            state        <= WB;
                            noc_in_ready <= 1'b0;
                            cnt_q        <= '0;
                            wbm_cyc_o    <= 1'b1;
                            wbm_stb_o    <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (in_hs && noc_in_last) begin
                        state        <= DRAIN_DONE;
                        noc_in_ready <= 1'b0;
                        drop_o       <= 1'b1;
                    end
                end
                DRAIN_DONE: begin
                    state        <= RX_HDR;
                    noc_in_ready <= 1'b1;
                end
                WB: begin
                    if (wb_done) begin
                        state         <= TX_HDR;
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        err_q         <= err_nxt;
                        noc_out_flit  <= rsp_hdr;
                        noc_out_last  <= wbm_we_o;
                        noc_out_valid <= 1'b1;
                        if (wbm_ack_i) begin
                            rdata_q <= wbm_dat_i;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                TX_HDR: begin
                    if (out_hs) begin
                        if (wbm_we_o) begin
                            state         <= RX_HDR;
                            noc_in_ready  <= 1'b1;
                            noc_out_flit  <= '0;
                            noc_out_last  <= 1'b0;
                            noc_out_valid <= 1'b0;
                        end else begin
                            state        <= TX_DATA;
                            noc_out_flit <= err_q ? '0 : rdata_q;
                            noc_out_last <= 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (out_hs) begin
                        state         <= RX_HDR;
                        noc_in_ready  <= 1'b1;
                        noc_out_flit  <= '0;
                        noc_out_last  <= 1'b0;
                        noc_out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= RX_HDR;
                end
            endcase
        end
    end

endmodule
